ctrl_pipe_hazard: RTL and testbench

//  - Consumer of the ID-stage control bundle produced by the opcode decoder.
//  - Registers that bundle through the ID/EX, EX/MEM and MEM/WB stages of the 16-bit pipelined core.
//  - Detects RAW hazards, inserts bubbles, flushes on a taken branch and (optionally) drives forwarding selects.

---
 rtl/ctrl_pipe_hazard_pkg.sv | 30 +++
 rtl/ctrl_pipe_hazard_hazard_unit.sv | 81 ++++++++
 rtl/ctrl_pipe_hazard.sv | 154 +++++++++++++++
 tb/tb_ctrl_pipe_hazard.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_hazard_pkg.sv
// Shared control-bundle types and encodings for the ctrl_pipe_hazard pipeline.
package ctrl_pkg;

  localparam int CTRL_ALUOP_W = 4;
  localparam int OPCODE_W     = 4;

  typedef struct packed {
    logic                    alu_src;
    logic                    branch;
    logic                    mem_read;
    logic                    mem_write;
    logic                    reg_write;
    logic                    mem_to_reg;
    logic [CTRL_ALUOP_W-1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_LHW  = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_SHW  = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 4'h5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/ctrl_pipe_hazard_hazard_unit.sv
// Combinational hazard logic: RAW/load-use stall, taken-branch flush and EX forwarding selects.
// Build option: FORWARDING_EN enables forwarding so only load-use stalls.
module hazard_unit
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_alu_src,
  input  logic              id_mem_write,
  input  logic              ex_branch,
  input  logic              ex_branch_taken,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_dst,
  output logic              stall,
  output logic              flush,
  output logic              bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  logic rs_used;
  logic rt_used;
  logic taken;
  logic ex_hit;
  logic hazard;

  // R0 is hardwired to zero, so it never makes a source "used" for hazard purposes
  assign rs_used = id_valid && (id_rs != '0);
  assign rt_used = id_valid && (!id_alu_src || id_mem_write) && (id_rt != '0);

  assign ex_hit = ex_reg_write && (ex_dst != '0) &&
                  ((rs_used && (id_rs == ex_dst)) || (rt_used && (id_rt == ex_dst)));

`ifdef FORWARDING_EN
  logic [REG_AW-1:0] ex_src [2];
  logic [1:0]        fwd_sel [2];

  assign ex_src[0] = ex_rs;
  assign ex_src[1] = ex_rt;

  // The nearer producer (EX/MEM) holds the newer value, so it wins over MEM/WB
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_sel[gi] =
      (mem_reg_write && (mem_dst != '0) && (mem_dst == ex_src[gi])) ? FWD_MEM :
      (wb_reg_write  && (wb_dst  != '0) && (wb_dst  == ex_src[gi])) ? FWD_WB  :
                                                                      FWD_REG;
  end

  assign fwd_a  = fwd_sel[0];
  assign fwd_b  = fwd_sel[1];
  assign hazard = ex_hit && ex_mem_read;
`else
  logic mem_hit;
  logic unused_fwd_inputs;

  assign mem_hit = mem_reg_write && (mem_dst != '0) &&
                   ((rs_used && (id_rs == mem_dst)) || (rt_used && (id_rt == mem_dst)));

  assign hazard = ex_hit || mem_hit;
  assign fwd_a  = FWD_REG;
  assign fwd_b  = FWD_REG;
  assign unused_fwd_inputs = ^{ex_rs, ex_rt, wb_reg_write, wb_dst, ex_mem_read};
`endif

  // A taken branch discards the ID instruction anyway, so it overrides any stall
  assign taken  = ex_branch && ex_branch_taken;
  assign flush  = taken;
  assign stall  = hazard && !taken;
  assign bubble = hazard || taken;

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// ID/EX, EX/MEM and MEM/WB control registers with hazard stall, branch flush and forwarding selects.
// Build option: define FORWARDING_EN to drive fwd_a/fwd_b; otherwise RAW hazards stall instead.
module ctrl_pipe_hazard
  import ctrl_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_reg_dest,
  input  logic               id_branch,
  input  logic               id_mem_read,
  input  logic               id_mem_to_reg,
  input  logic               id_mem_write,
  input  logic               id_alu_src,
  input  logic               id_reg_write,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               ex_branch_taken,
  output logic               stall,
  output logic               flush_ifid,
  output logic               ex_alu_src,
  output logic               ex_branch,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_reg_write,
  output logic               ex_mem_to_reg,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_dst,
  output logic               mem_mem_read,
  output logic               mem_mem_write,
  output logic               mem_reg_write,
  output logic               mem_mem_to_reg,
  output logic [REG_AW-1:0]  mem_dst,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic [REG_AW-1:0]  wb_dst,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b
);

  ctrl_t             ex_ctrl_reg, ex_ctrl_next;
  logic [REG_AW-1:0] ex_rs_reg, ex_rs_next;
  logic [REG_AW-1:0] ex_rt_reg, ex_rt_next;
  logic [REG_AW-1:0] ex_dst_reg, ex_dst_next;
  logic              mem_mem_read_reg, mem_mem_write_reg, mem_reg_write_reg, mem_mem_to_reg_reg;
  logic [REG_AW-1:0] mem_dst_reg;
  logic              wb_reg_write_reg, wb_mem_to_reg_reg;
  logic [REG_AW-1:0] wb_dst_reg;
  logic              bubble;

  hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_alu_src      (id_alu_src),
    .id_mem_write    (id_mem_write),
    .ex_branch       (ex_ctrl_reg.branch),
    .ex_branch_taken (ex_branch_taken),
    .ex_mem_read     (ex_ctrl_reg.mem_read),
    .ex_reg_write    (ex_ctrl_reg.reg_write),
    .ex_dst          (ex_dst_reg),
    .ex_rs           (ex_rs_reg),
    .ex_rt           (ex_rt_reg),
    .mem_reg_write   (mem_reg_write_reg),
    .mem_dst         (mem_dst_reg),
    .wb_reg_write    (wb_reg_write_reg),
    .wb_dst          (wb_dst_reg),
    .stall           (stall),
    .flush           (flush_ifid),
    .bubble          (bubble),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  // Destination is resolved here and zeroed for non-writers, so later stages never see a stale index
  always_comb begin
    ex_ctrl_next = CTRL_BUBBLE;
    ex_rs_next   = '0;
    ex_rt_next   = '0;
    ex_dst_next  = '0;
    if (id_valid && !bubble) begin
      ex_ctrl_next.alu_src    = id_alu_src;
      ex_ctrl_next.branch     = id_branch;
      ex_ctrl_next.mem_read   = id_mem_read;
      ex_ctrl_next.mem_write  = id_mem_write;
      ex_ctrl_next.reg_write  = id_reg_write;
      ex_ctrl_next.mem_to_reg = id_reg_write && id_mem_to_reg;
      ex_ctrl_next.alu_op     = CTRL_ALUOP_W'(id_alu_op);
      ex_rs_next              = id_rs;
      ex_rt_next              = id_rt;
      if (id_reg_write) begin
        ex_dst_next = id_reg_dest ? id_rd : id_rt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_reg        <= CTRL_BUBBLE;
      ex_rs_reg          <= '0;
      ex_rt_reg          <= '0;
      ex_dst_reg         <= '0;
      mem_mem_read_reg   <= 1'b0;
      mem_mem_write_reg  <= 1'b0;
      mem_reg_write_reg  <= 1'b0;
      mem_mem_to_reg_reg <= 1'b0;
      mem_dst_reg        <= '0;
      wb_reg_write_reg   <= 1'b0;
      wb_mem_to_reg_reg  <= 1'b0;
      wb_dst_reg         <= '0;
    end else begin
      ex_ctrl_reg        <= ex_ctrl_next;
      ex_rs_reg          <= ex_rs_next;
      ex_rt_reg          <= ex_rt_next;
      ex_dst_reg         <= ex_dst_next;
      // Later stages always advance; a stall only holds the front end
      mem_mem_read_reg   <= ex_ctrl_reg.mem_read;
      mem_mem_write_reg  <= ex_ctrl_reg.mem_write;
      mem_reg_write_reg  <= ex_ctrl_reg.reg_write;
      mem_mem_to_reg_reg <= ex_ctrl_reg.mem_to_reg;
      mem_dst_reg        <= ex_dst_reg;
      wb_reg_write_reg   <= mem_reg_write_reg;
      wb_mem_to_reg_reg  <= mem_mem_to_reg_reg;
      wb_dst_reg         <= mem_dst_reg;
    end
  end

  assign ex_alu_src     = ex_ctrl_reg.alu_src;
  assign ex_branch      = ex_ctrl_reg.branch;
  assign ex_mem_read    = ex_ctrl_reg.mem_read;
  assign ex_mem_write   = ex_ctrl_reg.mem_write;
  assign ex_reg_write   = ex_ctrl_reg.reg_write;
  assign ex_mem_to_reg  = ex_ctrl_reg.mem_to_reg;
  assign ex_alu_op      = ALUOP_W'(ex_ctrl_reg.alu_op);
  assign ex_rs          = ex_rs_reg;
  assign ex_rt          = ex_rt_reg;
  assign ex_dst         = ex_dst_reg;
  assign mem_mem_read   = mem_mem_read_reg;
  assign mem_mem_write  = mem_mem_write_reg;
  assign mem_reg_write  = mem_reg_write_reg;
  assign mem_mem_to_reg = mem_mem_to_reg_reg;
  assign mem_dst        = mem_dst_reg;
  assign wb_reg_write   = wb_reg_write_reg;
  assign wb_mem_to_reg  = wb_mem_to_reg_reg;
  assign wb_dst         = wb_dst_reg;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Scoreboard bench for ctrl_pipe_hazard: an instruction-level pipeline model predicts every cycle's outputs.
// Honours FORWARDING_EN the same way as the design.
`timescale 1ns/1ps
module tb_ctrl_pipe_hazard;

  localparam int REG_AW  = 4;
  localparam int ALUOP_W = 4;
  localparam int OUT_W   = 42;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic               id_valid, id_reg_dest, id_branch, id_mem_read, id_mem_to_reg;
  logic               id_mem_write, id_alu_src, id_reg_write, ex_branch_taken;
  logic [REG_AW-1:0]  id_rs, id_rt, id_rd;
  logic [ALUOP_W-1:0] id_alu_op;

  logic               stall, flush_ifid;
  logic               ex_alu_src, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic [REG_AW-1:0]  ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic               mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg;
  logic               wb_reg_write, wb_mem_to_reg;
  logic [1:0]         fwd_a, fwd_b;

  ctrl_pipe_hazard #(.REG_AW(REG_AW), .ALUOP_W(ALUOP_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_dest(id_reg_dest), .id_branch(id_branch), .id_mem_read(id_mem_read),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_alu_op(id_alu_op), .ex_branch_taken(ex_branch_taken),
    .stall(stall), .flush_ifid(flush_ifid), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dst(ex_dst), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg), .mem_dst(mem_dst),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [3:0] rs, rt, rd;
    logic       reg_dest, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [3:0] alu_op;
  } instr_t;

  // What an instruction looks like once it sits in a pipeline stage
  typedef struct packed {
    logic       alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg;
    logic [3:0] alu_op, rs, rt, dst;
  } stage_t;

  stage_t           pipe[$];   // [0]=EX, [1]=MEM, [2]=WB
  instr_t           prog[$];
  logic [OUT_W-1:0] sb[$];
  int               n_cmp = 0, n_bad = 0, n_mon = 0;
  int               stall_seen = 0, flush_seen = 0;
  int               rst_hold = 0;
  logic             squash_next = 1'b0;
  logic             rand_tk = 1'b0;

  function automatic instr_t i_nop();
    instr_t r;
    r = '0;
    return r;
  endfunction

  function automatic instr_t i_rtype(input int rd, input int rs, input int rt);
    instr_t r;
    r = '0;
    r.valid = 1'b1; r.rd = 4'(rd); r.rs = 4'(rs); r.rt = 4'(rt);
    r.reg_dest = 1'b1; r.reg_write = 1'b1; r.alu_op = 4'($urandom_range(0, 15));
    return r;
  endfunction

  function automatic instr_t i_addi(input int rt, input int rs);
    instr_t r;
    r = '0;
    r.valid = 1'b1; r.rt = 4'(rt); r.rs = 4'(rs); r.rd = 4'($urandom_range(0, 15));
    r.alu_src = 1'b1; r.reg_write = 1'b1; r.alu_op = 4'h2;
    return r;
  endfunction

  function automatic instr_t i_lhw(input int rt, input int rs);
    instr_t r;
    r = i_addi(rt, rs);
    r.mem_read = 1'b1; r.mem_to_reg = 1'b1;
    return r;
  endfunction

  // Stores and branches carry random don't-care reg_dest/mem_to_reg/rd bits
  function automatic instr_t i_shw(input int rt, input int rs);
    instr_t r;
    r = '0;
    r.valid = 1'b1; r.rt = 4'(rt); r.rs = 4'(rs); r.rd = 4'($urandom_range(0, 15));
    r.alu_src = 1'b1; r.mem_write = 1'b1; r.alu_op = 4'h2;
    r.reg_dest = 1'($urandom_range(0, 1)); r.mem_to_reg = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic instr_t i_beq(input int rs, input int rt);
    instr_t r;
    r = '0;
    r.valid = 1'b1; r.rs = 4'(rs); r.rt = 4'(rt); r.rd = 4'($urandom_range(0, 15));
    r.branch = 1'b1; r.alu_op = 4'h1;
    r.reg_dest = 1'($urandom_range(0, 1)); r.mem_to_reg = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic instr_t i_rand();
    instr_t      r;
    logic [31:0] w;
    case ($urandom_range(0, 5))
      0: r = i_rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      1: r = i_addi($urandom_range(0, 7), $urandom_range(0, 7));
      2: r = i_lhw($urandom_range(0, 7), $urandom_range(0, 7));
      3: r = i_shw($urandom_range(0, 7), $urandom_range(0, 7));
      4: r = i_beq($urandom_range(0, 7), $urandom_range(0, 7));
      default: begin
        w = $urandom;
        r = w[$bits(instr_t)-1:0];
        r.valid = 1'b0;
      end
    endcase
    return r;
  endfunction

  function automatic stage_t issue(input instr_t i);
    stage_t s;
    s = '0;
    if (i.valid) begin
      s.alu_src = i.alu_src; s.branch = i.branch; s.mem_read = i.mem_read;
      s.mem_write = i.mem_write; s.reg_write = i.reg_write;
      s.mem_to_reg = i.reg_write & i.mem_to_reg;
      s.alu_op = i.alu_op; s.rs = i.rs; s.rt = i.rt;
      if (i.reg_write) s.dst = i.reg_dest ? i.rd : i.rt;
    end
    return s;
  endfunction

  // A source is waiting when its producer's value cannot yet reach EX
  function automatic logic needs_stall(input instr_t i);
    logic [3:0] srcs[$];
    if (!i.valid) return 1'b0;
    srcs.push_back(i.rs);
    if (!i.alu_src || i.mem_write) srcs.push_back(i.rt);
    foreach (srcs[k]) begin
      if (srcs[k] != 4'd0) begin
`ifdef FORWARDING_EN
        if (pipe[0].mem_read && pipe[0].dst == srcs[k]) return 1'b1;
`else
        if (pipe[0].reg_write && pipe[0].dst == srcs[k]) return 1'b1;
        if (pipe[1].reg_write && pipe[1].dst == srcs[k]) return 1'b1;
`endif
      end
    end
    return 1'b0;
  endfunction

`ifdef FORWARDING_EN
  function automatic logic [1:0] fwd_for(input logic [3:0] src);
    if (pipe[1].reg_write && pipe[1].dst != 4'd0 && pipe[1].dst == src) return 2'b01;
    if (pipe[2].reg_write && pipe[2].dst != 4'd0 && pipe[2].dst == src) return 2'b10;
    return 2'b00;
  endfunction
`endif

  task automatic drive(input instr_t i);
    id_valid = i.valid; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
    id_reg_dest = i.reg_dest; id_branch = i.branch; id_mem_read = i.mem_read;
    id_mem_to_reg = i.mem_to_reg; id_mem_write = i.mem_write; id_alu_src = i.alu_src;
    id_reg_write = i.reg_write; id_alu_op = i.alu_op;
  endtask

  task automatic clear_pipe();
    pipe.delete();
    repeat (3) pipe.push_back('0);
  endtask

  task automatic step();
    instr_t     cur;
    logic       tk, st, fl, rst_now;
    logic [1:0] fa, fb;
    stage_t     ex, mm, wb;
    @(posedge clk);
    #1;
    rst_now = (rst_hold > 0);
    if (rst_hold > 0) rst_hold--;
    rst_n = !rst_now;
    if (rst_now) begin
      clear_pipe();
      squash_next = 1'b0;
    end
    cur = (squash_next || prog.size() == 0) ? i_nop() : prog[0];
    tk  = rand_tk ? ($urandom_range(0, 1) == 1) : 1'b1;
    drive(cur);
    ex_branch_taken = tk;
    ex = pipe[0]; mm = pipe[1]; wb = pipe[2];
    fl = ex.branch && tk;
    st = needs_stall(cur) && !fl;
`ifdef FORWARDING_EN
    fa = fwd_for(ex.rs);
    fb = fwd_for(ex.rt);
`else
    fa = 2'b00;
    fb = 2'b00;
`endif
    sb.push_back({st, fl, ex.alu_src, ex.branch, ex.mem_read, ex.mem_write, ex.reg_write,
                  ex.mem_to_reg, ex.alu_op, ex.rs, ex.rt, ex.dst,
                  mm.mem_read, mm.mem_write, mm.reg_write, mm.mem_to_reg, mm.dst,
                  wb.reg_write, wb.mem_to_reg, wb.dst, fa, fb});
    if (!rst_now) begin
      pipe.push_front((st || fl) ? stage_t'('0) : issue(cur));
      void'(pipe.pop_back());
      if (!squash_next && prog.size() > 0 && !st) void'(prog.pop_front());
      squash_next = fl;
    end
  endtask

  task automatic run_prog();
    int budget;
    budget = 0;
    while (prog.size() > 0 && budget < 5000) begin
      if (rand_tk && budget == 150) rst_hold = 2;
      step();
      budget++;
    end
    if (prog.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL run_budget actual=%0d left required=0 left", prog.size());
      prog.delete();
    end
  endtask

  task automatic expect_count(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, got, want);
    end else begin
      $display("ok   %s = %0d", name, got);
    end
  endtask

  task automatic scenario(input string name, input int want_stall, input int want_flush);
    int s0, f0;
    s0 = stall_seen; f0 = flush_seen;
    repeat (4) prog.push_back(i_nop());
    run_prog();
    @(negedge clk);
    #1;
    expect_count({name, "_stall_cycles"}, stall_seen - s0, want_stall);
    expect_count({name, "_flush_cycles"}, flush_seen - f0, want_flush);
  endtask

  // Monitor: compare the DUT every cycle against the queued prediction
  initial begin
    logic [OUT_W-1:0] act, exp_v;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_v = sb.pop_front();
        act = {stall, flush_ifid, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write,
               ex_mem_to_reg, ex_alu_op, ex_rs, ex_rt, ex_dst,
               mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg, mem_dst,
               wb_reg_write, wb_mem_to_reg, wb_dst, fwd_a, fwd_b};
        n_cmp++;
        if (act !== exp_v) begin
          n_bad++;
          $display("FAIL cycle%0d_outputs actual=%h required=%h", n_mon, act, exp_v);
        end else begin
          $display("ok   cycle%0d_outputs = %h", n_mon, act);
        end
        if (stall === 1'b1) stall_seen++;
        if (flush_ifid === 1'b1) flush_seen++;
        n_mon++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nofwd;
`ifdef FORWARDING_EN
    nofwd = 0;
`else
    nofwd = 1;
`endif
    drive(i_nop());
    ex_branch_taken = 1'b0;
    clear_pipe();

    rst_hold = 2;
    step();
    step();

    prog.push_back(i_lhw(3, 1));
    prog.push_back(i_rtype(4, 3, 5));
    scenario("load_use", nofwd ? 2 : 1, 0);

    prog.push_back(i_addi(2, 1));
    prog.push_back(i_rtype(6, 2, 2));
    scenario("alu_raw", nofwd ? 2 : 0, 0);

    prog.push_back(i_addi(2, 1));
    prog.push_back(i_beq(1, 1));
    prog.push_back(i_rtype(6, 2, 2));
    scenario("branch_flush", 0, 1);

    prog.push_back(i_addi(0, 1));
    prog.push_back(i_rtype(4, 0, 0));
    scenario("r0_writer", 0, 0);

    prog.push_back(i_addi(7, 1));
    prog.push_back(i_shw(7, 1));
    scenario("store_rt", nofwd ? 2 : 0, 0);

    rand_tk = 1'b1;
    repeat (300) prog.push_back(i_rand());
    run_prog();

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
